// File: rtl/aoc2_pkg.sv
// rtl/aoc2_pkg.sv - shared types, ASCII constants and helpers for the day-2 range feeder
package aoc2_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int MAX_DIGITS = 15;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    LO_ACC,
    HI_ACC,
    EMIT_HI,
    EMIT_LO,
    DONE,
    ERR
  } state_t;

  // Shift-and-add keeps the multiply out of the accumulate path.
  function automatic logic [DATA_WIDTH-1:0] mul10(input logic [DATA_WIDTH-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

endpackage

// File: rtl/aoc2_range_feeder_if.sv
// rtl/aoc2_range_feeder_if.sv - byte input stream, query output stream and status of the feeder
interface aoc2_range_feeder_if;

  logic [7:0]                     byte_in;
  logic                           byte_valid;
  logic                           byte_ready;
  logic [aoc2_pkg::DATA_WIDTH-1:0] q_n;
  logic [3:0]                     q_digs;
  logic                           q_sign;
  logic                           q_last;
  logic                           q_valid;
  logic                           q_ready;
  logic                           parse_err;
  logic                           done;

  modport master (
    output byte_in, byte_valid, q_ready,
    input  byte_ready, q_n, q_digs, q_sign, q_last, q_valid, parse_err, done
  );

  modport slave (
    input  byte_in, byte_valid, q_ready,
    output byte_ready, q_n, q_digs, q_sign, q_last, q_valid, parse_err, done
  );

endinterface

// File: rtl/aoc2_endpoint_seq.sv
// rtl/aoc2_endpoint_seq.sv - decade iterator turning one endpoint value into capped (n, digs) queries
module aoc2_endpoint_seq
  import aoc2_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] start_v,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] n,
  output logic [3:0]            digs,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] v_q, v_d, p_lo_q, p_lo_d, p_q, p_d, n_q, n_d;
  logic [4:0]            d_q, d_d;
  logic [3:0]            digs_q, digs_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] cur_v, cur_p_lo, cur_p;
  logic [4:0]            cur_d;

  // d/p_lo/p always describe the next decade to emit; start seeds the first one.
  always_comb begin
    cur_v    = start ? start_v : v_q;
    cur_d    = start ? 5'd2 : d_q;
    cur_p_lo = start ? DATA_WIDTH'(10) : p_lo_q;
    cur_p    = start ? DATA_WIDTH'(100) : p_q;
    v_d      = v_q;
    d_d      = d_q;
    p_lo_d   = p_lo_q;
    p_d      = p_q;
    n_d      = n_q;
    digs_d   = digs_q;
    last_d   = last_q;
    valid_d  = valid_q;
    if (start || (valid_q && ready)) begin
      v_d = cur_v;
      if (cur_v >= cur_p_lo) begin
        valid_d = 1'b1;
        n_d     = (cur_v < cur_p) ? cur_v : cur_p - DATA_WIDTH'(1);
        digs_d  = cur_d[3:0];
        last_d  = (cur_v < cur_p);
        d_d     = cur_d + 5'd1;
        p_lo_d  = cur_p;
        p_d     = mul10(cur_p);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      d_q     <= '0;
      p_lo_q  <= '0;
      p_q     <= '0;
      n_q     <= '0;
      digs_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      p_lo_q  <= p_lo_d;
      p_q     <= p_d;
      n_q     <= n_d;
      digs_q  <= digs_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign n     = n_q;
  assign digs  = digs_q;
  assign last  = last_q;

endmodule

// File: rtl/aoc2_range_feeder.sv
// rtl/aoc2_range_feeder.sv - parses "lo-hi" ASCII ranges into signed decade-capped group-count queries
module aoc2_range_feeder #(
  parameter int MAX_DIGITS = aoc2_pkg::MAX_DIGITS
) (
  input  logic                clock,
  input  logic                reset,
  aoc2_range_feeder_if.slave  bus
);
  import aoc2_pkg::*;

  localparam logic [4:0] MAX_D = 5'(MAX_DIGITS);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, lo_q, lo_d;
  logic [4:0]            ndig_q, ndig_d;
  logic                  final_q, final_d, sign_q, sign_d, null_q, null_d;

  logic                  seq_start, seq_valid, seq_last;
  logic [DATA_WIDTH-1:0] seq_v, seq_n, acc_next;
  logic [3:0]            seq_digs;
  logic                  byte_fire, is_digit, is_ignore, seq_done;

  assign bus.byte_ready = (state_q == LO_ACC) || (state_q == HI_ACC) || (state_q == ERR);
  assign byte_fire = bus.byte_valid && bus.byte_ready;
  assign is_digit  = (bus.byte_in >= CH_0) && (bus.byte_in <= CH_9);
  assign is_ignore = (bus.byte_in == CH_SP) || (bus.byte_in == CH_CR);
  assign acc_next  = mul10(acc_q) + DATA_WIDTH'(bus.byte_in - CH_0);
  assign seq_done  = !seq_valid || (bus.q_ready && seq_last);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    ndig_d    = ndig_q;
    final_d   = final_q;
    sign_d    = sign_q;
    null_d    = null_q;
    seq_start = 1'b0;
    seq_v     = acc_q;
    case (state_q)
      LO_ACC, HI_ACC: begin
        if (byte_fire) begin
          if (is_digit) begin
            if (ndig_q == MAX_D) begin
              state_d = ERR;
            end else begin
              acc_d  = acc_next;
              ndig_d = ndig_q + 5'd1;
            end
          end else if (is_ignore) begin
          end else if (state_q == LO_ACC && bus.byte_in == CH_DASH && ndig_q != 5'd0) begin
            lo_d    = acc_q;
            acc_d   = '0;
            ndig_d  = '0;
            state_d = HI_ACC;
          end else if (state_q == HI_ACC && (bus.byte_in == CH_COMMA || bus.byte_in == CH_NL)
                       && ndig_q != 5'd0 && lo_q != '0 && lo_q <= acc_q) begin
            final_d   = (bus.byte_in == CH_NL);
            sign_d    = 1'b1;
            seq_start = 1'b1;
            seq_v     = acc_q;
            acc_d     = '0;
            ndig_d    = '0;
            state_d   = EMIT_HI;
          end else begin
            state_d = ERR;
          end
        end
      end
      EMIT_HI: begin
        // An empty hi side implies an empty lo side, so a final range then needs the null query.
        if (seq_done) begin
          seq_start = 1'b1;
          seq_v     = lo_q - DATA_WIDTH'(1);
          sign_d    = 1'b0;
          null_d    = final_q && !seq_valid;
          state_d   = EMIT_LO;
        end
      end
      EMIT_LO: begin
        if (null_q) begin
          if (bus.q_ready) begin
            null_d  = 1'b0;
            state_d = DONE;
          end
        end else if (seq_done) begin
          state_d = final_q ? DONE : LO_ACC;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LO_ACC;
      acc_q   <= '0;
      lo_q    <= '0;
      ndig_q  <= '0;
      final_q <= 1'b0;
      sign_q  <= 1'b0;
      null_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      ndig_q  <= ndig_d;
      final_q <= final_d;
      sign_q  <= sign_d;
      null_q  <= null_d;
    end
  end

  aoc2_endpoint_seq u_seq (
    .clock   (clock),
    .reset   (reset),
    .start   (seq_start),
    .start_v (seq_v),
    .ready   (bus.q_ready),
    .valid   (seq_valid),
    .n       (seq_n),
    .digs    (seq_digs),
    .last    (seq_last)
  );

  // The hi side carries q_last itself only when lo-1 (< 10) contributes nothing.
  assign bus.q_valid   = seq_valid || null_q;
  assign bus.q_n       = null_q ? '0 : seq_n;
  assign bus.q_digs    = null_q ? 4'd0 : seq_digs;
  assign bus.q_sign    = null_q || sign_q;
  assign bus.q_last    = null_q || (seq_last && final_q && (!sign_q || lo_q < DATA_WIDTH'(11)));
  assign bus.parse_err = (state_q == ERR);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_aoc2_range_feeder.sv
// tb/tb_aoc2_range_feeder.sv - directed table-driven bench for aoc2_range_feeder
module tb_aoc2_range_feeder;

  typedef struct {
    logic            sign;
    longint unsigned n;
    int              digs;
    logic            last;
  } q_t;

  typedef struct {
    string text;
    int    first;
    int    count;
    int    err_at;
  } case_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  aoc2_range_feeder_if bus();

  aoc2_range_feeder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  q_t    exp_tab[32];
  int    n_exp = 0;
  case_t cases[10];
  q_t    cap[$];
  logic  cap_en = 1'b0;

  always @(negedge clock) begin : mon
    q_t t;
    if (cap_en && bus.q_valid && bus.q_ready) begin
      t.sign = bus.q_sign;
      t.n    = bus.q_n;
      t.digs = int'(bus.q_digs);
      t.last = bus.q_last;
      cap.push_back(t);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic add_q(input logic s, input longint unsigned n, input int d, input logic l);
    exp_tab[n_exp].sign = s;
    exp_tab[n_exp].n    = n;
    exp_tab[n_exp].digs = d;
    exp_tab[n_exp].last = l;
    n_exp++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " q_valid"}, bus.q_valid, 0);
    check({tag, " q_n"}, bus.q_n, 0);
    check({tag, " q_digs"}, bus.q_digs, 0);
    check({tag, " q_sign"}, bus.q_sign, 0);
    check({tag, " q_last"}, bus.q_last, 0);
    check({tag, " byte_ready"}, bus.byte_ready, 1);
    check({tag, " parse_err"}, bus.parse_err, 0);
    check({tag, " done"}, bus.done, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    bus.q_ready = 1'b1;
    @(negedge clock);
    check_idle("reset");
    reset = 1'b1;
  endtask

  // Offers each byte when byte_ready is seen; checks parse_err one cycle after each transfer.
  task automatic feed(input string s, input int err_at, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      int g;
      g = 0;
      while (!bus.byte_ready && g < 300) begin
        @(negedge clock);
        g++;
      end
      if (!bus.byte_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s byte_ready timeout at byte %0d: got 0, want 1", tag, i);
        return;
      end
      bus.byte_in = s[i];
      bus.byte_valid = 1'b1;
      @(negedge clock);
      bus.byte_valid = 1'b0;
      check($sformatf("%s parse_err after byte %0d", tag, i), bus.parse_err,
            (err_at >= 0 && i >= err_at));
    end
  endtask

  task automatic run_case(input int k);
    string tag;
    int g;
    tag = $sformatf("case%0d", k);
    @(negedge clock);
    cap.delete();
    cap_en = 1'b1;
    feed(cases[k].text, cases[k].err_at, tag);
    g = 0;
    while (!(bus.done || bus.parse_err) && g < 500) begin
      @(negedge clock);
      g++;
    end
    if (!(bus.done || bus.parse_err)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s completion timeout: got done=0 parse_err=0, want one set", tag);
    end
    repeat (2) @(negedge clock);
    cap_en = 1'b0;
    check({tag, " query count"}, cap.size(), cases[k].count);
    for (int j = 0; j < cases[k].count && j < cap.size(); j++) begin
      q_t e;
      e = exp_tab[cases[k].first + j];
      check($sformatf("%s q%0d n", tag, j), cap[j].n, e.n);
      check($sformatf("%s q%0d {sign,digs,last}", tag, j),
            {cap[j].sign, 4'(cap[j].digs), cap[j].last}, {e.sign, 4'(e.digs), e.last});
    end
    check({tag, " done"}, bus.done, cases[k].err_at < 0);
    check({tag, " parse_err"}, bus.parse_err, cases[k].err_at >= 0);
    check({tag, " byte_ready"}, bus.byte_ready, cases[k].err_at >= 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint unsigned pw;
    int g;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    bus.q_ready = 1'b1;

    add_q(1, 22, 2, 0);   add_q(0, 10, 2, 1);
    cases[0] = '{"11-22\n", 0, 2, -1};
    add_q(1, 99, 2, 0);   add_q(1, 115, 3, 0);  add_q(0, 94, 2, 0);
    add_q(1, 99, 2, 0);   add_q(1, 999, 3, 0);  add_q(1, 1012, 4, 0);
    add_q(0, 99, 2, 0);   add_q(0, 997, 3, 1);
    cases[1] = '{"95-115,998-1012\n", 2, 8, -1};
    add_q(1, 0, 0, 1);
    cases[2] = '{"1-9\n", 10, 1, -1};
    pw = 10;
    for (int d = 2; d <= 14; d++) begin
      pw = pw * 10;
      add_q(1, pw - 1, d, 0);
    end
    add_q(1, 64'd100000000000000, 15, 1);
    cases[3] = '{"1-100000000000000\n", 11, 14, -1};
    cases[4] = '{"12--5\n", 0, 0, 3};
    cases[5] = '{"30-20\n", 0, 0, 5};
    cases[6] = '{"1234567890123456-2\n", 0, 0, 15};
    cases[7] = '{"1 1 - 22\r\n", 0, 2, -1};
    cases[8] = '{"0-5\n", 0, 0, 3};
    cases[9] = '{"7-2x\n", 0, 0, 3};

    for (int k = 0; k < 10; k++) begin
      do_reset();
      run_case(k);
    end

    // Backpressure: first query stalled for three cycles.
    do_reset();
    bus.q_ready = 1'b0;
    feed("11-22\n", -1, "bp");
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp hold%0d q_valid", c), bus.q_valid, 1);
      check($sformatf("bp hold%0d q_n", c), bus.q_n, 22);
      check($sformatf("bp hold%0d {sign,digs,last}", c),
            {bus.q_sign, bus.q_digs, bus.q_last}, {1'b1, 4'd2, 1'b0});
      check($sformatf("bp hold%0d byte_ready", c), bus.byte_ready, 0);
      if (c == 3) bus.q_ready = 1'b1;
      @(negedge clock);
    end
    check("bp second q_valid", bus.q_valid, 1);
    check("bp second q_n", bus.q_n, 10);
    check("bp second {sign,digs,last}", {bus.q_sign, bus.q_digs, bus.q_last}, {1'b0, 4'd2, 1'b1});
    @(negedge clock);
    check("bp done", bus.done, 1);
    check("bp q_valid after done", bus.q_valid, 0);

    // Reset asserted while (+,115,3) is being presented.
    do_reset();
    feed("95-115\n", -1, "rst");
    g = 0;
    while (!(bus.q_valid && bus.q_digs == 4'd3) && g < 20) begin
      @(negedge clock);
      g++;
    end
    check("rst reached digs=3 query", bus.q_digs, 3);
    check("rst mid query n", bus.q_n, 115);
    reset = 1'b0;
    #1;
    check_idle("rst mid-emit");
    @(negedge clock);
    reset = 1'b1;
    run_case(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
